mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: consecutive denied dma_req cycles before a forced DMA grant.
REQ-002 Parameter DMA_BURST_MAX, default 4: maximum DMA beats per forced window.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-low reset.
REQ-006 en_in  in  1  global enable; when low, all state holds.
REQ-007 cpu_en  out  1  enable to the CPU pipeline; low means CPU frozen.
REQ-008 cpu_mem_write_en  in  4  CPU byte write enables.
REQ-009 cpu_mem_read_en  in  1  CPU read request.
REQ-010 cpu_mem_addr / cpu_mem_write_data  in  32 each  CPU address and store data.
REQ-011 cpu_mem_read_data  out  32  read data returned to the CPU.
REQ-012 dma_req  in  1  DMA beat request, held until granted.
REQ-013 dma_we  in  4  DMA byte enables (0 = read).
REQ-014 dma_addr / dma_wdata  in  32 each  DMA address and write data.
REQ-015 dma_gnt  out  1  DMA beat accepted this cycle.
REQ-016 dma_rdata  out  32 / dma_rvalid  out  1  DMA read data, valid one cycle after a granted read.
REQ-017 mem_write_en  out  4 / mem_read_en  out  1 / mem_addr, mem_write_data  out  32 / mem_read_data  in  32  shared single-port data memory, one-cycle read latency.

Function
REQ-018 The FSM SHALL have states CPU_OWN and DMA_FORCE.
REQ-019 CPU_OWN: port muxed to CPU and cpu_en = en_in.
REQ-020 CPU_OWN: if dma_req and the CPU is idle (cpu_mem_read_en=0, cpu_mem_write_en=0), the port SHALL be muxed to DMA and dma_gnt=1 with no CPU stall (opportunistic grant).
REQ-021 A granted DMA beat with dma_we=0 SHALL assert dma_rvalid exactly one cycle later with dma_rdata=mem_read_data; otherwise dma_rvalid=0.
REQ-022 cpu_rd_q SHALL be set the cycle after a CPU read issued with cpu_en=1.
REQ-023 While cpu_rd_q=1, mem_read_data SHALL be captured into a hold register.
REQ-024 cpu_mem_read_data = cpu_rd_q ? mem_read_data : hold register, so CPU data remains stable across stalls.
REQ-025 DMA_FORCE: cpu_en=0, port muxed to DMA, dma_gnt=dma_req.
REQ-026 DMA_FORCE: a beat counter SHALL increment per grant.
REQ-027 DMA_FORCE SHALL return to CPU_OWN the cycle after dma_req is low or the DMA_BURST_MAX-th beat is granted.
REQ-028 en_in=0: mem_write_en=0, mem_read_en=0, dma_gnt=0, cpu_en=0, and all registers hold.
REQ-029 When a CPU access and a forced DMA grant collide, the DMA beat SHALL win; the CPU access is not performed and is re-presented after cpu_en returns high.
REQ-030 Counters SHALL saturate and never wrap.

Reset
REQ-031 While rst=0 at a clock edge: state=CPU_OWN, starve and beat counters=0, cpu_rd_q=0, dma_rd_q=0, hold register=0.
REQ-032 During reset, cpu_en=0, dma_gnt=0, dma_rvalid=0, and all memory enables are 0.
REQ-033 Reset mid-burst SHALL abort the burst; no dma_rvalid is produced for the aborted read.

Configuration
REQ-034 With MEM_ARB_STARVE_EN defined, a starve counter SHALL count cycles in which dma_req=1 and dma_gnt=0, and clear on a grant or when dma_req=0.
REQ-035 With MEM_ARB_STARVE_EN defined, when the starve counter reaches STARVE_LIMIT, the FSM SHALL enter DMA_FORCE next cycle.
REQ-036 Without MEM_ARB_STARVE_EN, DMA_FORCE is unreachable, the starve counter is absent, and DMA is served only opportunistically (strict CPU priority).

Structure
REQ-037 Package mem_arb_pkg SHALL hold the state encoding, the STARVE_LIMIT/DMA_BURST_MAX defaults, and the port-select encoding.
REQ-038 The CPU read-data capture SHALL be sub-module mem_arb_rdata_hold (cpu_rd_q flag, hold register, output mux).

Verification
REQ-039 CPU idle, DMA read beat to addr 0x40 (mem holds 0xDEADBEEF) -> dma_gnt same cycle, dma_rvalid=1 next cycle with 0xDEADBEEF; cpu_en stays 1.
REQ-040 CPU issuing back-to-back loads, dma_req held, macro defined -> after 8 denied cycles, cpu_en=0, 4 DMA beats granted, then cpu_en=1.
REQ-041 Same stimulus without the macro -> dma_gnt never asserted; cpu_en never drops.
REQ-042 CPU load of 0x12345678 at cycle N, forced DMA read of 0xAAAAAAAA at N+1 -> cpu_mem_read_data remains 0x12345678 through the stall.
REQ-043 Reset asserted during the 2nd beat of a forced burst -> next cycle state=CPU_OWN, dma_rvalid=0, counters=0.
REQ-044 en_in=0 with dma_req=1 and a CPU store pending -> mem_write_en=0, dma_gnt=0, and state unchanged for the whole interval.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory port arbiter.
// Holds the FSM state encoding, the port-select encoding, the default
// starvation limit and burst length, and a counter-width helper.
package mem_arb_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    localparam int STARVE_LIMIT_DEFAULT  = 8;
    localparam int DMA_BURST_MAX_DEFAULT = 4;

    typedef enum logic {
        CPU_OWN   = 1'b0,
        DMA_FORCE = 1'b1
    } arb_state_t;

    typedef enum logic {
        SEL_CPU = 1'b0,
        SEL_DMA = 1'b1
    } port_sel_t;

    // Bits needed to hold the values 0..limit inclusive.
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arb_rdata_hold.sv
// mem_arb_rdata_hold: keeps CPU load data stable while the CPU is frozen.
// The memory output is forwarded in the cycle after a CPU read and copied
// into a hold register, which drives the CPU afterwards.
module mem_arb_rdata_hold
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en_in,
    input  logic              rd_issue,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [DATA_W-1:0] cpu_mem_read_data
);

    logic              cpu_rd_q;
    logic [DATA_W-1:0] hold_data;

    // Flag returning CPU read data and capture it for later stall cycles
    always_ff @(posedge clk) begin
        if (!rst) begin
            cpu_rd_q  <= 1'b0;
            hold_data <= '0;
        end else if (en_in) begin
            cpu_rd_q <= rd_issue;
            if (cpu_rd_q) begin
                hold_data <= mem_read_data;
            end
        end
    end

    assign cpu_mem_read_data = cpu_rd_q ? mem_read_data : hold_data;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port data memory between the CPU and
// a DMA engine. DMA beats are granted in CPU-idle cycles at no CPU cost.
// Build macro MEM_ARB_STARVE_EN adds a starve counter that forces a DMA
// burst (CPU frozen) after STARVE_LIMIT refused cycles; without it the CPU
// has strict priority and DMA is served only opportunistically.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT  = STARVE_LIMIT_DEFAULT,
    parameter int DMA_BURST_MAX = DMA_BURST_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_in,
    output logic              cpu_en,
    input  logic [BE_W-1:0]   cpu_mem_write_en,
    input  logic              cpu_mem_read_en,
    input  logic [DATA_W-1:0] cpu_mem_addr,
    input  logic [DATA_W-1:0] cpu_mem_write_data,
    output logic [DATA_W-1:0] cpu_mem_read_data,
    input  logic              dma_req,
    input  logic [BE_W-1:0]   dma_we,
    input  logic [DATA_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic [BE_W-1:0]   mem_write_en,
    output logic              mem_read_en,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int BW = cnt_width(DMA_BURST_MAX);

    if (STARVE_LIMIT < 1 || DMA_BURST_MAX < 1) begin : g_param_check
        $error("mem_port_arbiter: STARVE_LIMIT and DMA_BURST_MAX must be >= 1");
    end

    arb_state_t    state;
    port_sel_t     sel;
    logic [BW-1:0] beat_cnt;
    logic          dma_rd_q;
    logic          live;
    logic          cpu_idle;
    logic          grant;
    logic          cpu_go;
    logic          force_req;

    function automatic logic [BW-1:0] beat_inc(input logic [BW-1:0] v);
        return (v >= BW'(DMA_BURST_MAX)) ? v : v + BW'(1);
    endfunction

    // rst is active-low: the block is live only out of reset and enabled
    assign live     = rst & en_in;
    assign cpu_idle = !cpu_mem_read_en && (cpu_mem_write_en == '0);

    // Port ownership and grant decision for the current cycle
    always_comb begin
        sel    = SEL_CPU;
        grant  = 1'b0;
        cpu_go = 1'b0;
        case (state)
            CPU_OWN: begin
                cpu_go = live;
                if (dma_req && cpu_idle) begin
                    sel   = SEL_DMA;
                    grant = live;
                end
            end
            DMA_FORCE: begin
                sel   = SEL_DMA;
                grant = live & dma_req;
            end
            default: begin
                sel = SEL_CPU;
            end
        endcase
    end

`ifdef MEM_ARB_STARVE_EN
    localparam int SW = cnt_width(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;

    function automatic logic [SW-1:0] starve_inc(input logic [SW-1:0] v);
        return (v >= SW'(STARVE_LIMIT)) ? v : v + SW'(1);
    endfunction

    // Next starve count: refused cycles accumulate, any grant or idle DMA clears
    always_comb begin
        starve_nxt = '0;
        if (dma_req && !grant) begin
            starve_nxt = starve_inc(starve_cnt);
        end
    end

    assign force_req = (starve_nxt >= SW'(STARVE_LIMIT));

    // Track how long a pending DMA beat has been refused
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (en_in) begin
            starve_cnt <= starve_nxt;
        end
    end
`else
    assign force_req = 1'b0;
`endif

    // Ownership FSM, burst beat counter and DMA read-return flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= CPU_OWN;
            beat_cnt <= '0;
            dma_rd_q <= 1'b0;
        end else if (en_in) begin
            dma_rd_q <= grant && (dma_we == '0);
            case (state)
                CPU_OWN: begin
                    beat_cnt <= '0;
                    if (force_req) begin
                        state <= DMA_FORCE;
                    end
                end
                DMA_FORCE: begin
                    if (!dma_req || (grant && beat_cnt == BW'(DMA_BURST_MAX - 1))) begin
                        state    <= CPU_OWN;
                        beat_cnt <= '0;
                    end else if (grant) begin
                        beat_cnt <= beat_inc(beat_cnt);
                    end
                end
                default: begin
                    state    <= CPU_OWN;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

    assign cpu_en     = cpu_go;
    assign dma_gnt    = grant;
    assign dma_rdata  = mem_read_data;
    assign dma_rvalid = dma_rd_q & live;

    assign mem_addr       = (sel == SEL_DMA) ? dma_addr  : cpu_mem_addr;
    assign mem_write_data = (sel == SEL_DMA) ? dma_wdata : cpu_mem_write_data;
    assign mem_write_en   = (sel == SEL_DMA) ? (grant ? dma_we : '0)
                                             : (cpu_go ? cpu_mem_write_en : '0);
    assign mem_read_en    = (sel == SEL_DMA) ? (grant && (dma_we == '0))
                                             : (cpu_go && cpu_mem_read_en);

    mem_arb_rdata_hold u_rdata_hold (
        .clk               (clk),
        .rst               (rst),
        .en_in             (en_in),
        .rd_issue          (cpu_go && cpu_mem_read_en),
        .mem_read_data     (mem_read_data),
        .cpu_mem_read_data (cpu_mem_read_data)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector bench for mem_port_arbiter with a
// small read-only memory model (one-cycle read latency).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_in;
    logic        cpu_en;
    logic [3:0]  cpu_mem_write_en;
    logic        cpu_mem_read_en;
    logic [31:0] cpu_mem_addr;
    logic [31:0] cpu_mem_write_data;
    logic [31:0] cpu_mem_read_data;
    logic        dma_req;
    logic [3:0]  dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;
    logic [3:0]  mem_write_en;
    logic        mem_read_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data = 32'h0;

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        logic        r;
        logic        e;
        logic [3:0]  cwe;
        logic        cre;
        logic [31:0] ca;
        logic [31:0] cwd;
        logic        dq;
        logic [3:0]  dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        xe;
        logic        xg;
        logic        xr;
        logic [31:0] xrd;
        logic [3:0]  xwe;
        logic        xre;
        logic [31:0] xa;
        logic [31:0] xwd;
        logic [31:0] xcrd;
    } vec_t;

    vec_t vq[$];

    mem_port_arbiter dut (
        .clk                (clk),
        .rst                (rst),
        .en_in              (en_in),
        .cpu_en             (cpu_en),
        .cpu_mem_write_en   (cpu_mem_write_en),
        .cpu_mem_read_en    (cpu_mem_read_en),
        .cpu_mem_addr       (cpu_mem_addr),
        .cpu_mem_write_data (cpu_mem_write_data),
        .cpu_mem_read_data  (cpu_mem_read_data),
        .dma_req            (dma_req),
        .dma_we             (dma_we),
        .dma_addr           (dma_addr),
        .dma_wdata          (dma_wdata),
        .dma_gnt            (dma_gnt),
        .dma_rdata          (dma_rdata),
        .dma_rvalid         (dma_rvalid),
        .mem_write_en       (mem_write_en),
        .mem_read_en        (mem_read_en),
        .mem_addr           (mem_addr),
        .mem_write_data     (mem_write_data),
        .mem_read_data      (mem_read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h12345678;
            32'h20:  return 32'hAAAAAAAA;
            32'h30:  return 32'hCAFEF00D;
            32'h40:  return 32'hDEADBEEF;
            32'h50:  return 32'h5555AAAA;
            default: return 32'h0;
        endcase
    endfunction

    // Single-port memory model: registered read, one cycle latency
    always @(posedge clk) begin
        if (mem_read_en) mem_read_data <= rom(mem_addr);
    end

    function automatic vec_t mk(
        input logic r, input logic e,
        input logic [3:0] cwe, input logic cre, input logic [31:0] ca, input logic [31:0] cwd,
        input logic dq, input logic [3:0] dwe, input logic [31:0] da, input logic [31:0] dwd,
        input logic xe, input logic xg, input logic xr, input logic [31:0] xrd,
        input logic [3:0] xwe, input logic xre, input logic [31:0] xa, input logic [31:0] xwd,
        input logic [31:0] xcrd);
        vec_t v;
        v.r = r; v.e = e; v.cwe = cwe; v.cre = cre; v.ca = ca; v.cwd = cwd;
        v.dq = dq; v.dwe = dwe; v.da = da; v.dwd = dwd;
        v.xe = xe; v.xg = xg; v.xr = xr; v.xrd = xrd;
        v.xwe = xwe; v.xre = xre; v.xa = xa; v.xwd = xwd; v.xcrd = xcrd;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag, input int idx);
        logic ok;
        @(posedge clk);
        #1;
        rst = v.r; en_in = v.e;
        cpu_mem_write_en = v.cwe; cpu_mem_read_en = v.cre;
        cpu_mem_addr = v.ca; cpu_mem_write_data = v.cwd;
        dma_req = v.dq; dma_we = v.dwe; dma_addr = v.da; dma_wdata = v.dwd;
        @(negedge clk);
        nvec++;
        ok = (cpu_en === v.xe) && (dma_gnt === v.xg) && (dma_rvalid === v.xr) &&
             (!v.xr || dma_rdata === v.xrd) && (mem_write_en === v.xwe) &&
             (mem_read_en === v.xre) && (mem_addr === v.xa) &&
             ((v.xwe == 4'h0) || mem_write_data === v.xwd) &&
             (cpu_mem_read_data === v.xcrd);
        if (!ok) begin
            nfail++;
            $display("FAIL %s[%0d]: got cpu_en=%b gnt=%b rvalid=%b rdata=%h mwe=%h mre=%b maddr=%h mwd=%h crdata=%h; expected cpu_en=%b gnt=%b rvalid=%b rdata=%h mwe=%h mre=%b maddr=%h mwd=%h crdata=%h",
                     tag, idx, cpu_en, dma_gnt, dma_rvalid, dma_rdata, mem_write_en, mem_read_en,
                     mem_addr, mem_write_data, cpu_mem_read_data,
                     v.xe, v.xg, v.xr, v.xrd, v.xwe, v.xre, v.xa, v.xwd, v.xcrd);
        end
    endtask

    initial begin
        rst = 1'b0; en_in = 1'b1;
        cpu_mem_write_en = 4'h0; cpu_mem_read_en = 1'b0;
        cpu_mem_addr = 32'h0; cpu_mem_write_data = 32'h0;
        dma_req = 1'b0; dma_we = 4'h0; dma_addr = 32'h0; dma_wdata = 32'h0;
        repeat (2) @(posedge clk);

        //          r     e     cwe   cre   ca      cwd            dq    dwe   da      dwd            xe    xg    xr    xrd            xwe   xre   xa      xwd            xcrd
        vq.push_back(mk(1'b0, 1'b1, 4'h0, 1'b1, 32'h10, 32'h0,         1'b1, 4'h0, 32'h40, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         4'h0, 1'b0, 32'h10, 32'h0,         32'h0));
        vq.push_back(mk(1'b1, 1'b1, 4'h0, 1'b0, 32'h0,  32'h0,         1'b1, 4'h0, 32'h40, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         4'h0, 1'b1, 32'h40, 32'h0,         32'h0));
        vq.push_back(mk(1'b1, 1'b1, 4'h0, 1'b0, 32'h0,  32'h0,         1'b0, 4'h0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b1, 32'hDEADBEEF,  4'h0, 1'b0, 32'h0,  32'h0,         32'h0));
        vq.push_back(mk(1'b1, 1'b1, 4'h0, 1'b1, 32'h10, 32'h0,         1'b1, 4'h0, 32'h20, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         4'h0, 1'b1, 32'h10, 32'h0,         32'h0));
        vq.push_back(mk(1'b1, 1'b1, 4'h0, 1'b0, 32'h0,  32'h0,         1'b1, 4'h0, 32'h20, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         4'h0, 1'b1, 32'h20, 32'h0,         32'h12345678));
        vq.push_back(mk(1'b1, 1'b1, 4'h0, 1'b0, 32'h0,  32'h0,         1'b0, 4'h0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b1, 32'hAAAAAAAA,  4'h0, 1'b0, 32'h0,  32'h0,         32'h12345678));
        vq.push_back(mk(1'b1, 1'b1, 4'h3, 1'b0, 32'h80, 32'h0000BEEF,  1'b1, 4'hF, 32'h90, 32'h11112222,  1'b1, 1'b0, 1'b0, 32'h0,         4'h3, 1'b0, 32'h80, 32'h0000BEEF,  32'h12345678));
        vq.push_back(mk(1'b1, 1'b1, 4'h0, 1'b0, 32'h0,  32'h0,         1'b1, 4'hF, 32'h90, 32'h11112222,  1'b1, 1'b1, 1'b0, 32'h0,         4'hF, 1'b0, 32'h90, 32'h11112222,  32'h12345678));
        vq.push_back(mk(1'b1, 1'b0, 4'hF, 1'b0, 32'h84, 32'h01020304,  1'b1, 4'h0, 32'h40, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         4'h0, 1'b0, 32'h84, 32'h0,         32'h12345678));
        vq.push_back(mk(1'b1, 1'b0, 4'hF, 1'b0, 32'h84, 32'h01020304,  1'b1, 4'h0, 32'h40, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         4'h0, 1'b0, 32'h84, 32'h0,         32'h12345678));
        vq.push_back(mk(1'b1, 1'b1, 4'hF, 1'b0, 32'h84, 32'h01020304,  1'b1, 4'h0, 32'h40, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         4'hF, 1'b0, 32'h84, 32'h01020304,  32'h12345678));
        vq.push_back(mk(1'b1, 1'b1, 4'h0, 1'b0, 32'h0,  32'h0,         1'b1, 4'h0, 32'h30, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         4'h0, 1'b1, 32'h30, 32'h0,         32'h12345678));
        vq.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 32'h0,  32'h0,         1'b0, 4'h0, 32'h0,  32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         4'h0, 1'b0, 32'h0,  32'h0,         32'h12345678));
        vq.push_back(mk(1'b1, 1'b1, 4'h0, 1'b0, 32'h0,  32'h0,         1'b0, 4'h0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b1, 32'hCAFEF00D,  4'h0, 1'b0, 32'h0,  32'h0,         32'h12345678));
        vq.push_back(mk(1'b1, 1'b1, 4'h0, 1'b1, 32'h50, 32'h0,         1'b0, 4'h0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         4'h0, 1'b1, 32'h50, 32'h0,         32'h12345678));
        vq.push_back(mk(1'b1, 1'b0, 4'h0, 1'b1, 32'h40, 32'h0,         1'b0, 4'h0, 32'h0,  32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         4'h0, 1'b0, 32'h40, 32'h0,         32'h5555AAAA));
        vq.push_back(mk(1'b1, 1'b1, 4'h0, 1'b0, 32'h0,  32'h0,         1'b0, 4'h0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         4'h0, 1'b0, 32'h0,  32'h0,         32'h5555AAAA));
        vq.push_back(mk(1'b1, 1'b1, 4'h0, 1'b0, 32'h0,  32'h0,         1'b1, 4'h0, 32'h10, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         4'h0, 1'b1, 32'h10, 32'h0,         32'h5555AAAA));
        vq.push_back(mk(1'b1, 1'b1, 4'h0, 1'b0, 32'h0,  32'h0,         1'b0, 4'h0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b1, 32'h12345678,  4'h0, 1'b0, 32'h0,  32'h0,         32'h5555AAAA));
        vq.push_back(mk(1'b0, 1'b1, 4'h0, 1'b1, 32'h10, 32'h0,         1'b1, 4'h0, 32'h40, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         4'h0, 1'b0, 32'h10, 32'h0,         32'h5555AAAA));
        vq.push_back(mk(1'b1, 1'b1, 4'h0, 1'b0, 32'h0,  32'h0,         1'b0, 4'h0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         4'h0, 1'b0, 32'h0,  32'h0,         32'h0));

        for (int i = 0; i < vq.size(); i++) begin
            run_vec(vq[i], "table", i);
        end

`ifdef MEM_ARB_STARVE_EN
        // Forced bursts: starvation, CPU data hold through the stall, reset mid-burst
        for (int c = 1; c <= 35; c++) begin
            vec_t        v;
            logic        force_c;
            logic        in_force;
            logic        rst_c;
            logic        rv;
            logic [31:0] ca;
            logic [31:0] crd;
            ca       = (c <= 7) ? 32'h30 : 32'h10;
            force_c  = (c >= 9 && c <= 12) || (c == 21) || (c >= 31 && c <= 34);
            in_force = force_c || (c == 22);
            rst_c    = (c != 22);
            rv       = (c >= 10 && c <= 13) || (c >= 32 && c <= 35);
            crd      = (c == 1 || c == 23) ? 32'h0 : (c <= 8) ? 32'hCAFEF00D : 32'h12345678;
            v = mk(rst_c, 1'b1, 4'h0, 1'b1, ca, 32'h0, 1'b1, 4'h0, 32'h20, 32'h0,
                   !in_force, force_c, rv, 32'hAAAAAAAA, 4'h0, rst_c,
                   in_force ? 32'h20 : ca, 32'h0, crd);
            run_vec(v, "force", c);
        end
`else
        // Strict CPU priority: a held DMA request is never granted behind busy loads
        for (int c = 1; c <= 20; c++) begin
            vec_t        v;
            logic [31:0] ca;
            logic [31:0] crd;
            ca  = (c % 2 == 1) ? 32'h10 : 32'h30;
            crd = (c == 1) ? 32'h0 : rom((c % 2 == 1) ? 32'h30 : 32'h10);
            v = mk(1'b1, 1'b1, 4'h0, 1'b1, ca, 32'h0, 1'b1, 4'h0, 32'h40, 32'h0,
                   1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, ca, 32'h0, crd);
            run_vec(v, "strict", c);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
